arcade_input_ctrl: RTL and testbench
====================================

// Module: arcade_input_ctrl
// PURPOSE
//  Input front-end sitting directly upstream of the game core in the emu top level. Decodes
//  hps_io ps2_key toggle events into held key states and merges them with joystick_0 and
//  joystick_1. Produces registered P1/P2 controls, starts and test. Shapes each coin input
//  into a fixed-width pulse with an enforced gap, so the core's coin sampling never misses
//  or double-counts a credit.
// PARAMETERS
//  COIN_PULSE  24'd600000  coin output high time in clk_sys cycles (50 ms at 12 MHz)
//  COIN_GAP    24'd600000  minimum coin output low time after a pulse, in clk_sys cycles
// PORTS
//  clk_sys      in   1   system clock (12 MHz); all logic on rising edge
//  reset_n      in   1   asynchronous, active-low reset
//  ps2_key      in   11  [10]=toggle on each event, [9]=pressed, [8:0]=code (bit 8 = E0 ext)
//  joystick_0   in   16  [0]R [1]L [2]D [3]U [4]F1 [5]F2 [6]St1 [7]St2 [8]Coin, active high
//  joystick_1   in   16  same layout as joystick_0, player 2 pad
//  p1           out  6   {fire2,fire1,up,down,left,right} player 1, active high
//  p2           out  6   same layout, player 2
//  start1       out  1   start 1P
//  start2       out  1   start 2P
//  coin1        out  1   shaped coin pulse, channel 1
//  coin2        out  1   shaped coin pulse, channel 2
//  test         out  1   service/test switch
// BEHAVIOUR
//  Reset
//   - All outputs 0. Key-state regs 0. Coin FSMs in IDLE with counters 0 and pending 0.
//   - armed=0.
//  Key event detect
//   - First clk_sys edge after reset release: old_tog<=ps2_key[10], armed<=1; no event fires.
//   - Thereafter, event when armed && ps2_key[10]!=old_tog. old_tog updates every cycle.
//   - On event, key reg <= ps2_key[9]. Unlisted codes are ignored.
//   - Ext-any (bit 8 don't-care): X75 up1, X72 down1, X6B left1, X74 right1.
//   - 029 fire1_1, 014 fire2_1.
//   - 005/016 start1, 006/01E start2. A code pair drives one shared start register.
//   - 02E coin1, 036 coin2.
//   - 02D up2, 02B down2, 023 left2, 034 right2, 01C fire1_2, 02C test.
//  Merge
//   - p1 = key_p1 | joystick_0[5:0] remapped to {5,4,3,2,1,0}. p2 likewise from joystick_1.
//   - start1 = key | joystick_0[6] | joystick_1[6]; start2 = key | joystick_0[7] | joystick_1[7].
//   - raw_coin1 = key_coin1 | joystick_0[8]; raw_coin2 = key_coin2 | joystick_1[8].
//   - p1, p2, start*, test are registered: 1 cycle after joystick change; 2 cycles after
//     ps2 toggle (event reg + output reg).
//  Coin FSM (per channel, identical)
//   - rise = raw_coin & ~raw_coin_d (raw_coin_d registered).
//   - IDLE: rise -> PULSE, cnt<=COIN_PULSE-1, coin<=1.
//   - PULSE: cnt!=0 -> cnt--. cnt==0 -> GAP, cnt<=COIN_GAP-1, coin<=0.
//     The output is therefore high exactly COIN_PULSE cycles.
//   - GAP: cnt!=0 -> cnt--. cnt==0 -> pending ? (PULSE, pending<=0, coin<=1) : IDLE.
//   - A rise during PULSE or GAP sets pending. Pending saturates at 1; further rises are lost.
//   - A rise in the same cycle GAP expires with pending=0: go straight to PULSE, do not wait
//     for IDLE.
//   - A held raw coin produces exactly one pulse; it must fall and rise again to count again.
//  Counter width: 24 bits. COIN_PULSE and COIN_GAP must be >=1.
//  reset_n asserted mid-pulse: coin drops to 0 asynchronously, pending is cleared, and the
//  FSM returns to IDLE.
// TESTING
//  - COIN_PULSE=4, COIN_GAP=3 for the bench.
//  - Reset with ps2_key[10]=1, release -> no key event, all outputs 0 for 10 cycles.
//  - Toggle ps2_key={1'b?,1,9'h175} -> p1[3]=1 two cycles later.
//    Toggle again with pressed=0 -> p1[3]=0.
//  - joystick_1[4]=1 -> p2[4]=1 next cycle, and p1 unchanged.
//  - joystick_0[8] held high 20 cycles -> coin1 high exactly 4 cycles, then 0; one pulse only.
//  - Two coin1 rises 2 cycles apart -> pulse (4 high), gap (3 low), second pulse (4 high).
//    A third rise inside the first PULSE is lost.
//  - Assert reset_n=0 during coin2 PULSE -> coin2=0 immediately.
//    After release, no pulse until a new rise.

Source files
------------

// File: rtl/arcade_input_ctrl.sv
// arcade_input_ctrl: merges PS/2 key events and two joysticks into registered
// player controls, and shapes each coin input into a fixed-width pulse with a gap.
//   clk_sys     system clock, all logic on the rising edge
//   reset_n     asynchronous active-low reset
//   ps2_key     [10] toggles on each event, [9] pressed, [8:0] scan code (bit 8 = E0)
//   joystick_0  player 1 pad: [0]R [1]L [2]D [3]U [4]F1 [5]F2 [6]St1 [7]St2 [8]Coin
//   joystick_1  player 2 pad, same layout
//   p1, p2      {fire2,fire1,up,down,left,right}, registered
//   start1/2    start buttons, registered
//   coin1/2     shaped coin pulses
//   test        service/test switch, registered
module arcade_input_ctrl #(
    parameter logic [23:0] COIN_PULSE = 24'd600000,
    parameter logic [23:0] COIN_GAP   = 24'd600000
) (
    input  logic        clk_sys,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic [15:0] joystick_0,
    input  logic [15:0] joystick_1,
    output logic [5:0]  p1,
    output logic [5:0]  p2,
    output logic        start1,
    output logic        start2,
    output logic        coin1,
    output logic        coin2,
    output logic        test
);
    typedef enum logic [1:0] {IDLE, PULSE, GAP} coin_state_t;
    logic       armed;
    logic       old_tog;
    logic       key_evt;
    logic [5:0] key_p1;
    logic [4:0] key_p2;
    logic       key_start1;
    logic       key_start2;
    logic       key_coin1;
    logic       key_coin2;
    logic       key_test;
    logic [1:0] raw_coin;
    logic [1:0] coin_q;
    logic       unused_joy;
    assign unused_joy = ^{joystick_0[15:9], joystick_1[15:9]};
    // the first edge after reset only captures the toggle level, so a stale
    // toggle state never registers as a key event
    assign key_evt = armed && (ps2_key[10] != old_tog);
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            armed      <= 1'b0;
            old_tog    <= 1'b0;
            key_p1     <= '0;
            key_p2     <= '0;
            key_start1 <= 1'b0;
            key_start2 <= 1'b0;
            key_coin1  <= 1'b0;
            key_coin2  <= 1'b0;
            key_test   <= 1'b0;
        end else begin
            armed   <= 1'b1;
            old_tog <= ps2_key[10];
            if (key_evt) begin
                case (ps2_key[8:0])
                    9'h075, 9'h175: key_p1[3]  <= ps2_key[9];
                    9'h072, 9'h172: key_p1[2]  <= ps2_key[9];
                    9'h06B, 9'h16B: key_p1[1]  <= ps2_key[9];
                    9'h074, 9'h174: key_p1[0]  <= ps2_key[9];
                    9'h029:         key_p1[4]  <= ps2_key[9];
                    9'h014:         key_p1[5]  <= ps2_key[9];
                    9'h005, 9'h016: key_start1 <= ps2_key[9];
                    9'h006, 9'h01E: key_start2 <= ps2_key[9];
                    9'h02E:         key_coin1  <= ps2_key[9];
                    9'h036:         key_coin2  <= ps2_key[9];
                    9'h02D:         key_p2[3]  <= ps2_key[9];
                    9'h02B:         key_p2[2]  <= ps2_key[9];
                    9'h023:         key_p2[1]  <= ps2_key[9];
                    9'h034:         key_p2[0]  <= ps2_key[9];
                    9'h01C:         key_p2[4]  <= ps2_key[9];
                    9'h02C:         key_test   <= ps2_key[9];
                    default: ;
                endcase
            end
        end
    end
    always_ff @(posedge clk_sys or negedge reset_n) begin
        if (!reset_n) begin
            p1     <= '0;
            p2     <= '0;
            start1 <= 1'b0;
            start2 <= 1'b0;
            test   <= 1'b0;
        end else begin
            p1     <= key_p1 | joystick_0[5:0];
            p2     <= {joystick_1[5], key_p2 | joystick_1[4:0]};
            start1 <= key_start1 | joystick_0[6] | joystick_1[6];
            start2 <= key_start2 | joystick_0[7] | joystick_1[7];
            test   <= key_test;
        end
    end
    assign raw_coin = {key_coin2 | joystick_1[8], key_coin1 | joystick_0[8]};
    for (genvar i = 0; i < 2; i++) begin : g_coin
        coin_state_t state;
        logic [23:0] cnt;
        logic        pending;
        logic        raw_d;
        logic        coin_r;
        logic        rise;
        assign rise      = raw_coin[i] & ~raw_d;
        assign coin_q[i] = coin_r;
        always_ff @(posedge clk_sys or negedge reset_n) begin
            if (!reset_n) begin
                state   <= IDLE;
                cnt     <= '0;
                pending <= 1'b0;
                raw_d   <= 1'b0;
                coin_r  <= 1'b0;
            end else begin
                raw_d <= raw_coin[i];
                case (state)
                    IDLE: if (rise) begin
                        state  <= PULSE;
                        cnt    <= COIN_PULSE - 24'd1;
                        coin_r <= 1'b1;
                    end
                    PULSE: begin
                        if (rise) pending <= 1'b1;
                        if (cnt != '0) cnt <= cnt - 24'd1;
                        else begin
                            state  <= GAP;
                            cnt    <= COIN_GAP - 24'd1;
                            coin_r <= 1'b0;
                        end
                    end
                    GAP: if (cnt != '0) begin
                        cnt <= cnt - 24'd1;
                        if (rise) pending <= 1'b1;
                    end else if (pending || rise) begin
                        // a pending credit starts now; a rise on this same edge
                        // is kept as the next pending credit
                        state   <= PULSE;
                        cnt     <= COIN_PULSE - 24'd1;
                        coin_r  <= 1'b1;
                        pending <= pending & rise;
                    end else state <= IDLE;
                    default: state <= IDLE;
                endcase
            end
        end
    end
    assign coin1 = coin_q[0];
    assign coin2 = coin_q[1];
endmodule

// File: tb/tb_arcade_input_ctrl.sv
// tb_arcade_input_ctrl: randomized and directed checks of arcade_input_ctrl against a behavioural model.
module tb_arcade_input_ctrl;
    localparam int P = 4;
    localparam int G = 3;
    logic        clk_sys = 1'b0;
    logic        reset_n = 1'b0;
    logic [10:0] ps2_key = 11'h400;
    logic [15:0] joystick_0 = '0;
    logic [15:0] joystick_1 = '0;
    logic [5:0]  p1, p2;
    logic        start1, start2, coin1, coin2, test;
    int tests = 0;
    int fails = 0;
    int cyc = 0;
    arcade_input_ctrl #(.COIN_PULSE(24'd4), .COIN_GAP(24'd3)) dut (
        .clk_sys(clk_sys), .reset_n(reset_n), .ps2_key(ps2_key),
        .joystick_0(joystick_0), .joystick_1(joystick_1),
        .p1(p1), .p2(p2), .start1(start1), .start2(start2),
        .coin1(coin1), .coin2(coin2), .test(test)
    );
    always #5 clk_sys = ~clk_sys;
    // key functions: 0..5 p1 bits, 6..10 p2 bits, 12 start1, 13 start2, 14 coin1, 15 coin2, 16 test
    logic [8:0] tbl_code [18] = '{9'h075, 9'h072, 9'h06B, 9'h074, 9'h029, 9'h014, 9'h005, 9'h016, 9'h006,
                                  9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h02C};
    int         tbl_fn   [18] = '{3, 2, 1, 0, 4, 5, 12, 12, 13, 13, 14, 15, 9, 8, 7, 6, 10, 16};
    logic [8:0] rnd_code [20] = '{9'h175, 9'h075, 9'h172, 9'h06B, 9'h16B, 9'h074, 9'h029, 9'h014, 9'h005, 9'h016,
                                  9'h006, 9'h01E, 9'h02E, 9'h036, 9'h02D, 9'h02B, 9'h023, 9'h034, 9'h01C, 9'h02C};
    bit  kfn [17];
    bit  armed_m, tog_m;
    bit  rawd_m [2];
    int  start_t [2];
    int  end_t [2];
    bit  pend [2];
    logic [5:0] exp_p1, exp_p2;
    logic exp_s1, exp_s2, exp_test;
    logic exp_coin [2];
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s at cycle %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask
    function automatic int fn_of(input logic [8:0] c);
        for (int k = 0; k < 18; k++) begin
            logic [8:0] t;
            t = tbl_code[k];
            if (t == c || (tbl_fn[k] <= 3 && t[7:0] == c[7:0])) return tbl_fn[k];
        end
        return -1;
    endfunction
    task automatic model_reset();
        for (int k = 0; k < 17; k++) kfn[k] = 1'b0;
        armed_m = 1'b0;
        tog_m = 1'b0;
        exp_p1 = '0; exp_p2 = '0; exp_s1 = 0; exp_s2 = 0; exp_test = 0;
        for (int c = 0; c < 2; c++) begin
            rawd_m[c] = 0; start_t[c] = -1000; end_t[c] = 0; pend[c] = 0; exp_coin[c] = 0;
        end
    endtask
    task automatic model_edge();
        bit raw, rise;
        int f;
        exp_p1 = {kfn[5], kfn[4], kfn[3], kfn[2], kfn[1], kfn[0]} | joystick_0[5:0];
        exp_p2 = {1'b0, kfn[10], kfn[9], kfn[8], kfn[7], kfn[6]} | joystick_1[5:0];
        exp_s1 = kfn[12] | joystick_0[6] | joystick_1[6];
        exp_s2 = kfn[13] | joystick_0[7] | joystick_1[7];
        exp_test = kfn[16];
        for (int c = 0; c < 2; c++) begin
            raw = kfn[14 + c] | (c == 0 ? joystick_0[8] : joystick_1[8]);
            rise = raw && !rawd_m[c];
            rawd_m[c] = raw;
            if (pend[c] && cyc == end_t[c]) begin
                start_t[c] = cyc; end_t[c] = cyc + P + G; pend[c] = 0;
            end
            if (rise) begin
                if (cyc >= end_t[c]) begin
                    start_t[c] = cyc; end_t[c] = cyc + P + G;
                end else pend[c] = 1;
            end
            exp_coin[c] = (cyc >= start_t[c]) && (cyc < start_t[c] + P);
        end
        if (armed_m && ps2_key[10] != tog_m) begin
            f = fn_of(ps2_key[8:0]);
            if (f >= 0) kfn[f] = ps2_key[9];
        end
        tog_m = ps2_key[10];
        armed_m = 1'b1;
    endtask
    task automatic tick();
        @(posedge clk_sys);
        cyc++;
        model_edge();
        #1;
        check("p1", 32'(p1), 32'(exp_p1));
        check("p2", 32'(p2), 32'(exp_p2));
        check("start1", 32'(start1), 32'(exp_s1));
        check("start2", 32'(start2), 32'(exp_s2));
        check("test", 32'(test), 32'(exp_test));
        check("coin1", 32'(coin1), 32'(exp_coin[0]));
        check("coin2", 32'(coin2), 32'(exp_coin[1]));
    endtask
    task automatic ps2_evt(input logic [8:0] code, input logic pressed);
        ps2_key = {~ps2_key[10], pressed, code};
    endtask
    initial begin
        int hi, edges;
        logic prev;
        logic pat [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
        model_reset();
        repeat (3) @(posedge clk_sys);
        #1;
        check("reset_outs", 32'({p1, p2, start1, start2, coin1, coin2, test}), 32'h0);
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("post_reset_zero", 32'({p1, p2, start1, start2, coin1, coin2, test}), 32'h0);
        end
        ps2_evt(9'h175, 1'b1);
        tick();
        check("up1_lat1", 32'(p1[3]), 32'h0);
        tick();
        check("up1_press", 32'(p1[3]), 32'h1);
        ps2_evt(9'h175, 1'b0);
        tick();
        tick();
        check("up1_release", 32'(p1[3]), 32'h0);
        joystick_1[4] = 1'b1;
        tick();
        check("p2_fire1_joy", 32'(p2[4]), 32'h1);
        check("p1_unchanged", 32'(p1), 32'h0);
        joystick_0[8] = 1'b1;
        hi = 0; edges = 0; prev = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (coin1) hi++;
            if (coin1 && !prev) edges++;
            prev = coin1;
        end
        check("coin1_hold_high", 32'(hi), 32'd4);
        check("coin1_hold_pulses", 32'(edges), 32'd1);
        joystick_0[8] = 1'b0;
        repeat (10) tick();
        for (int i = 0; i < 16; i++) begin
            joystick_0[8] = (i < 5) ? pat[i] : 1'b0;
            tick();
            check("coin1_seq", 32'(coin1), 32'((i < 4) || (i >= 7 && i < 11)));
        end
        joystick_1[8] = 1'b1;
        tick();
        tick();
        check("coin2_mid_pulse", 32'(coin2), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        check("coin2_async_reset", 32'(coin2), 32'h0);
        model_reset();
        joystick_1[8] = 1'b0;
        repeat (2) @(posedge clk_sys);
        #1;
        reset_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("coin2_quiet_after_reset", 32'(coin2), 32'h0);
        end
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 4) == 0)
                ps2_evt(($urandom_range(0, 5) == 0) ? 9'($urandom) : rnd_code[$urandom_range(0, 19)], 1'($urandom));
            if ($urandom_range(0, 9) == 0) joystick_0[7:0] = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 9) == 0) joystick_1[7:0] = 8'($urandom) & 8'($urandom);
            if ($urandom_range(0, 5) == 0) joystick_0[8] = ~joystick_0[8];
            if ($urandom_range(0, 5) == 0) joystick_1[8] = ~joystick_1[8];
            tick();
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
